writeback_buffer: RTL and testbench

//  Writeback stage directly upstream of the register file.
//  - Collects results from the ALU and memory paths and queues them in a small in-order FIFO.
//  - Drains one entry per cycle into the register file write port (write_enable/write_address/data_in).
//  - Forwards queued-but-unwritten results to the decode read ports, so reads never see stale data.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/writeback_match.sv | 44 ++++
 rtl/writeback_buffer.sv | 129 ++++++++++++
 tb/tb_writeback_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults, the zero-register constant and the queue entry type for the writeback stage.
// Revision: 1.0
`default_nettype none

package wb_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DEPTH      = 4;

  // r0 is hardwired; results targeting it are accepted and dropped.
  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] address;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/writeback_match.sv
// writeback_match: youngest-entry address match across the occupied part of a circular queue.
// Revision: 1.0
`default_nettype none

module writeback_match
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int DEPTH      = WB_DEPTH
) (
  input  logic [ADDR_WIDTH-1:0]        entry_addr_i [DEPTH],
  input  logic [DATA_WIDTH-1:0]        entry_data_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     head_i,
  input  logic [$clog2(DEPTH+1)-1:0]   count_i,
  input  logic [ADDR_WIDTH-1:0]        read_address_i,
  output logic                         hit_o,
  output logic [DATA_WIDTH-1:0]        data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] slot;

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    slot   = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_i + PW'(i);
      if ((CW'(i) < count_i) &&
          (read_address_i != ADDR_WIDTH'(ZERO_REG)) &&
          (entry_addr_i[slot] == read_address_i)) begin
        hit_o  = 1'b1;
        data_o = entry_data_i[slot];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/writeback_buffer.sv
// writeback_buffer: in-order result queue between the ALU/memory paths and the register file write port.
// Revision: 1.0
`default_nettype none

module writeback_buffer
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = WB_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [ADDR_WIDTH-1:0]        mem_address,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_WIDTH-1:0]        alu_address,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  output logic                         write_enable,
  output logic [ADDR_WIDTH-1:0]        write_address,
  output logic [DATA_WIDTH-1:0]        data_in,
  input  logic [ADDR_WIDTH-1:0]        read1_address,
  input  logic [ADDR_WIDTH-1:0]        read2_address,
  output logic                         fwd1_hit,
  output logic [DATA_WIDTH-1:0]        fwd1_data,
  output logic                         fwd2_hit,
  output logic [DATA_WIDTH-1:0]        fwd2_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = CW + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic          pop;
  logic          need_m;
  logic          store_m;
  logic          store_a;
  logic [FW-1:0] free;
  logic [PW-1:0] alu_slot;

  assign pop    = (count_q != '0);
  // The head always drains this edge, so its slot counts as free.
  assign free   = FW'(DEPTH) - FW'(count_q) + FW'(pop);
  assign need_m = mem_valid && (mem_address != ADDR_WIDTH'(ZERO_REG));

  assign mem_ready = (mem_address == ADDR_WIDTH'(ZERO_REG)) || (free >= FW'(1));
  assign alu_ready = (alu_address == ADDR_WIDTH'(ZERO_REG)) ||
                     (free >= (FW'(1) + FW'(need_m)));

  assign store_m  = need_m && mem_ready;
  assign store_a  = alu_valid && alu_ready && (alu_address != ADDR_WIDTH'(ZERO_REG));
  assign alu_slot = tail_q + PW'(store_m);

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(store_m) + PW'(store_a);
    count_d = count_q + CW'(store_m) + CW'(store_a) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone qualifies every read of it.
  always_ff @(posedge clk) begin
    if (store_m) begin
      addr_q[tail_q] <= mem_address;
      data_q[tail_q] <= mem_data;
    end
    if (store_a) begin
      addr_q[alu_slot] <= alu_address;
      data_q[alu_slot] <= alu_data;
    end
  end

  assign write_enable  = pop;
  assign write_address = pop ? addr_q[head_q] : '0;
  assign data_in       = pop ? data_q[head_q] : '0;
  assign count         = count_q;

  writeback_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_match1 (
    .entry_addr_i   (addr_q),
    .entry_data_i   (data_q),
    .head_i         (head_q),
    .count_i        (count_q),
    .read_address_i (read1_address),
    .hit_o          (fwd1_hit),
    .data_o         (fwd1_data)
  );

  writeback_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_match2 (
    .entry_addr_i   (addr_q),
    .entry_data_i   (data_q),
    .head_i         (head_q),
    .count_i        (count_q),
    .read_address_i (read2_address),
    .hit_o          (fwd2_hit),
    .data_o         (fwd2_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: randomized and directed stimulus against a queue-based model of the writeback buffer.
// Revision: 1.0
`default_nettype none

module tb_writeback_buffer;
  import wb_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          mem_valid = 1'b0, alu_valid = 1'b0;
  logic          mem_ready, alu_ready;
  logic [AW-1:0] mem_address = '0, alu_address = '0;
  logic [DW-1:0] mem_data = '0, alu_data = '0;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] data_in;
  logic [AW-1:0] read1_address = '0, read2_address = '0;
  logic          fwd1_hit, fwd2_hit;
  logic [DW-1:0] fwd1_data, fwd2_data;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  writeback_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_address(mem_address), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_address(alu_address), .alu_data(alu_data),
    .write_enable(write_enable), .write_address(write_address), .data_in(data_in),
    .read1_address(read1_address), .read2_address(read2_address),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .count(count)
  );

  // Register file driven by the DUT write port.
  logic [DW-1:0] rf [32] = '{default: '0};
  int            dut_writes = 0;
  always @(posedge clk) begin
    if (write_enable) begin
      rf[write_address] <= data_in;
      dut_writes        <= dut_writes + 1;
    end
  end

  // Reference model: plain queue of pending results plus the register file it implies.
  wb_entry_t     q[$];
  logic [DW-1:0] mregs [32] = '{default: '0};
  int            model_pops = 0;
  int            passed = 0;
  int            total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic fwd_expect(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 0)
      foreach (q[i]) if (q[i].address == a) begin hit = 1'b1; d = q[i].data; end
  endtask

  // Checks every output against the model for the current inputs, then advances the model by one edge.
  task automatic compare_and_step();
    int            n, free;
    logic          need_m, exp_mr, exp_ar, h;
    logic [DW-1:0] d;
    wb_entry_t     e;
    n = q.size();
    chk("count", count, n);
    chk("write_enable", write_enable, n != 0);
    chk("write_address", write_address, (n != 0) ? q[0].address : '0);
    chk("data_in", data_in, (n != 0) ? q[0].data : '0);
    free   = DEPTH - n + ((n != 0) ? 1 : 0);
    need_m = mem_valid && (mem_address != 0);
    exp_mr = (mem_address == 0) || (free >= 1);
    exp_ar = (alu_address == 0) || (free >= 1 + (need_m ? 1 : 0));
    chk("mem_ready", mem_ready, exp_mr);
    chk("alu_ready", alu_ready, exp_ar);
    fwd_expect(read1_address, h, d);
    chk("fwd1_hit", fwd1_hit, h);
    chk("fwd1_data", fwd1_data, d);
    fwd_expect(read2_address, h, d);
    chk("fwd2_hit", fwd2_hit, h);
    chk("fwd2_data", fwd2_data, d);
    if (n != 0) begin
      mregs[q[0].address] = q[0].data;
      void'(q.pop_front());
      model_pops++;
    end
    if (mem_valid && exp_mr && mem_address != 0) begin
      e.address = mem_address; e.data = mem_data; q.push_back(e);
    end
    if (alu_valid && exp_ar && alu_address != 0) begin
      e.address = alu_address; e.data = alu_data; q.push_back(e);
    end
  endtask

  task automatic cycle(input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    mem_valid = mv; mem_address = ma; mem_data = md;
    alu_valid = av; alu_address = aa; alu_data = ad;
    read1_address = r1; read2_address = r2;
    #1;
    compare_and_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
  endtask

  initial begin
    // Power-on reset
    #1 reset_n = 1'b0;
    #1;
    chk("reset count", count, 0);
    chk("reset write_enable", write_enable, 0);
    chk("reset write_address", write_address, 0);
    chk("reset data_in", data_in, 0);
    chk("reset fwd1_hit", fwd1_hit, 0);
    chk("reset fwd2_data", fwd2_data, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single ALU write
    cycle(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    chk("alu write_enable", write_enable, 1);
    chk("alu write_address", write_address, 5);
    chk("alu data_in", data_in, 32'hDEADBEEF);
    chk("alu fwd1_data", fwd1_data, 32'hDEADBEEF);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd5, 5'd0);
    chk("rf r5", rf[5], 32'hDEADBEEF);

    // Dual accept to the same register
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
    chk("dual count", count, 2);
    chk("dual fwd1_hit", fwd1_hit, 1);
    chk("dual fwd1_data", fwd1_data, 32'h22);
    chk("dual head data", data_in, 32'h11);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd0);
    chk("rf r3 first", rf[3], 32'h11);
    chk("dual second head", data_in, 32'h22);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd0);
    chk("rf r3 last", rf[3], 32'h22);

    // Zero register
    alu_valid = 1'b1; alu_address = '0; alu_data = 32'hFFFFFFFF; read1_address = '0;
    #1;
    chk("zero alu_ready", alu_ready, 1);
    chk("zero fwd1_hit", fwd1_hit, 0);
    cycle(1'b0, '0, '0, 1'b1, '0, 32'hFFFFFFFF, 5'd0, 5'd0);
    chk("zero count", count, 0);
    chk("zero write_enable", write_enable, 0);

    // Backpressure: both paths hold valid continuously
    for (int i = 0; i < 3; i++)
      cycle(1'b1, AW'($urandom_range(1, 31)), $urandom, 1'b1, AW'($urandom_range(1, 31)), $urandom,
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
    #1;
    chk("bp count full", count, 4);
    chk("bp alu stalled", alu_ready, 0);
    chk("bp mem_ready", mem_ready, 1);
    for (int i = 0; i < 12; i++)
      cycle(1'b1, AW'($urandom_range(1, 31)), $urandom, 1'b1, AW'($urandom_range(1, 31)), $urandom,
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
    idle(6);

    // Wrap-around stream
    for (int i = 1; i <= 20; i++)
      cycle(1'b1, AW'(i), DW'(i * 32'h100), 1'b0, '0, '0, AW'($urandom_range(1, 20)), AW'(i - 1));
    idle(3);
    for (int i = 1; i <= 20; i++) chk($sformatf("stream rf r%0d", i), rf[i], DW'(i * 32'h100));

    // Randomized traffic
    random_cycles(300);

    // Asynchronous reset mid-stream with three entries pending
    idle(5);
    cycle(1'b1, AW'($urandom_range(1, 31)), $urandom, 1'b1, AW'($urandom_range(1, 31)), $urandom, '0, '0);
    cycle(1'b1, AW'($urandom_range(1, 31)), $urandom, 1'b1, AW'($urandom_range(1, 31)), $urandom, '0, '0);
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("pre-reset count", count, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset count", count, 0);
    chk("async reset write_enable", write_enable, 0);
    q.delete();
    @(posedge clk); #4 reset_n = 1'b1;
    @(posedge clk); #1;
    idle(4);
    random_cycles(200);
    idle(6);

    chk("write total", dut_writes, model_pops);
    for (int i = 0; i < 32; i++) chk($sformatf("final rf r%0d", i), rf[i], mregs[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
